// File: rtl/jg3_eval_sched.sv
// jg3_eval_sched
// Round-robin scheduler that shares one combinational JG3 evaluator between
// two requesters. A granted code is driven on eval_abc, the evaluator is
// given EVAL_CYCLES cycles to settle, then X/Y are sampled and returned with
// the requester id over a valid/ready response channel.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   req0_valid/abc/ready       requester 0 code channel (ready pulses on grant)
//   req1_valid/abc/ready       requester 1 code channel (ready pulses on grant)
//   eval_abc                   registered code driven to the shared evaluator
//   eval_x, eval_y             evaluator outputs
//   rsp_valid/id/x/y/ready     response channel
//   chk_err                    sticky evaluator mismatch flag
//
// Optional feature: define JG3_EVAL_CHECK_EN to build the internal reference
// model that checks every sample and raises chk_err on a mismatch. Without
// it chk_err is tied low.
module jg3_eval_sched #(
    parameter int unsigned EVAL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_abc,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_abc,
    output logic       req1_ready,
    output logic [2:0] eval_abc,
    input  logic       eval_x,
    input  logic       eval_y,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic       rsp_x,
    output logic       rsp_y,
    input  logic       rsp_ready,
    output logic       chk_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last settle count value; the sample is taken when the counter hits it.
    localparam logic [3:0] CNT_LAST = 4'(EVAL_CYCLES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [3:0] cnt_r;
    logic       grant_id_r;
    logic       last_grant_r;
    logic [2:0] eval_abc_r;
    logic       rsp_valid_r;
    logic       rsp_id_r;
    logic       rsp_x_r;
    logic       rsp_y_r;
    logic       grant_s;
    logic       grant_sel_s;
    logic       sample_s;
    logic       req0_ready_s;
    logic       req1_ready_s;

    // Next-state, grant arbitration and the one-cycle ready pulses.
    always_comb begin
        state_s      = state_r;
        grant_s      = 1'b0;
        grant_sel_s  = 1'b0;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        sample_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    // Tie goes to whoever was not served last.
                    grant_s     = 1'b1;
                    grant_sel_s = ~last_grant_r;
                end else if (req0_valid) begin
                    grant_s     = 1'b1;
                    grant_sel_s = 1'b0;
                end else if (req1_valid) begin
                    grant_s     = 1'b1;
                    grant_sel_s = 1'b1;
                end else begin
                    grant_s     = 1'b0;
                    grant_sel_s = 1'b0;
                end
                if (grant_s) begin
                    state_s      = EVAL;
                    req0_ready_s = ~grant_sel_s;
                    req1_ready_s = grant_sel_s;
                end else begin
                    state_s = IDLE;
                end
            end
            EVAL: begin
                if (cnt_r == CNT_LAST) begin
                    sample_s = 1'b1;
                    state_s  = RESP;
                end else begin
                    state_s = EVAL;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, settle counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            grant_id_r   <= 1'b0;
            last_grant_r <= 1'b1;
            eval_abc_r   <= 3'd0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_x_r      <= 1'b0;
            rsp_y_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                eval_abc_r   <= grant_sel_s ? req1_abc : req0_abc;
                grant_id_r   <= grant_sel_s;
                last_grant_r <= grant_sel_s;
                cnt_r        <= 4'd0;
            end else if (state_r == EVAL) begin
                cnt_r <= cnt_r + 4'd1;
            end
            if (sample_s) begin
                rsp_x_r     <= eval_x;
                rsp_y_r     <= eval_y;
                rsp_id_r    <= grant_id_r;
                rsp_valid_r <= 1'b1;
            end else if ((state_r == RESP) && rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

`ifdef JG3_EVAL_CHECK_EN
    logic chk_err_r;

    // Reference JG3 truth table, returned as {x, y}.
    function automatic logic [1:0] jg3_ref(input logic [2:0] abc);
        logic x_v;
        logic y_v;
        x_v = (abc == 3'b101) || (abc == 3'b110) || (abc == 3'b111);
        y_v = (abc == 3'b000) || (abc == 3'b111);
        return {x_v, y_v};
    endfunction

    // Sticky mismatch flag; compared against the code held on eval_abc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err_r <= 1'b0;
        end else if (sample_s && ({eval_x, eval_y} != jg3_ref(eval_abc_r))) begin
            chk_err_r <= 1'b1;
        end
    end

    assign chk_err = chk_err_r;
`else
    assign chk_err = 1'b0;
`endif

    assign req0_ready = req0_ready_s;
    assign req1_ready = req1_ready_s;
    assign eval_abc   = eval_abc_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_x      = rsp_x_r;
    assign rsp_y      = rsp_y_r;

endmodule
